// File: rtl/hazard_pkg.sv
// Shared constants for the Tuse/Tnew hazard scoreboard:
// default widths, stage indices, class Tuse/Tnew values.
package hazard_pkg;

  localparam int REG_AW_D = 5;
  localparam int STAGES_D = 3;
  localparam int TW_D     = 2;

  localparam int STG_E = 1;
  localparam int STG_M = 2;
  localparam int STG_W = 3;

  localparam logic [TW_D-1:0] TNEW_ALU  = 2'd1;
  localparam logic [TW_D-1:0] TNEW_LOAD = 2'd2;
  localparam logic [TW_D-1:0] TNEW_LINK = 2'd0;

  localparam logic [TW_D-1:0] TUSE_BRANCH   = 2'd0;
  localparam logic [TW_D-1:0] TUSE_JR       = 2'd0;
  localparam logic [TW_D-1:0] TUSE_ALU      = 2'd1;
  localparam logic [TW_D-1:0] TUSE_STORE_RT = 2'd2;

  localparam int SEL_RF = 0;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle: operand/destination info in,
// stall and forward selects out.
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int TW     = 2,
  parameter int SELW   = 2
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [TW-1:0]     id_tuse_rs;
  logic [TW-1:0]     id_tuse_rt;
  logic              id_wr_en;
  logic [REG_AW-1:0] id_dst;
  logic [TW-1:0]     id_tnew;
  logic              flush;
  logic              stall;
  logic [SELW-1:0]   fwd_rs_sel;
  logic [SELW-1:0]   fwd_rt_sel;
  logic              pend_rs;
  logic              pend_rt;

  modport master (
    output id_valid, id_rs, id_rt,
    output id_use_rs, id_use_rt,
    output id_tuse_rs, id_tuse_rt,
    output id_wr_en, id_dst, id_tnew,
    output flush,
    input  stall, fwd_rs_sel, fwd_rt_sel,
    input  pend_rs, pend_rt
  );

  modport slave (
    input  id_valid, id_rs, id_rt,
    input  id_use_rs, id_use_rt,
    input  id_tuse_rs, id_tuse_rt,
    input  id_wr_en, id_dst, id_tnew,
    input  flush,
    output stall, fwd_rs_sel, fwd_rt_sel,
    output pend_rs, pend_rt
  );
endinterface

// File: rtl/hazard_match.sv
// One-operand youngest-match finder plus the
// stall / forward / pending decision.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_D,
  parameter int STAGES = STAGES_D,
  parameter int TW     = TW_D,
  parameter int SELW   = $clog2(STAGES + 1)
) (
  input  logic [STAGES:1]             v,
  input  logic [STAGES:1][REG_AW-1:0] dst,
  input  logic [STAGES:1][TW-1:0]     tnew,
  input  logic                        use_en,
  input  logic [REG_AW-1:0]           src,
  input  logic [TW-1:0]               tuse,
  output logic                        hz,
  output logic [SELW-1:0]             sel,
  output logic                        pend
);

  logic            hit;
  logic [SELW-1:0] k_hit;
  logic [TW-1:0]   t_hit;
  logic            live;

  // Scan oldest to youngest so the youngest hit wins.
  always_comb begin
    hit   = 1'b0;
    k_hit = '0;
    t_hit = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (v[k] && dst[k] == src) begin
        hit   = 1'b1;
        k_hit = SELW'(k);
        t_hit = tnew[k];
      end
    end
  end

  assign live = use_en && (src != '0) && hit;
  assign hz   = live && (t_hit > tuse);
  assign sel  = (live && t_hit == '0)
              ? k_hit : SELW'(SEL_RF);
  assign pend = live && !hz && (t_hit != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard scoreboard beside decode.
// Define HAZ_STATS_EN to add the stall_cnt counter port.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_D,
  parameter int STAGES = STAGES_D,
  parameter int TW     = TW_D,
  parameter int SELW   = $clog2(STAGES + 1)
) (
  input  logic clk,
  input  logic reset_n,
  hazard_scoreboard_if.slave bus
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  logic [STAGES:1]             v;
  logic [STAGES:1][REG_AW-1:0] dst;
  logic [STAGES:1][TW-1:0]     tnew;
  logic                        hz_rs;
  logic                        hz_rt;
  logic                        load;

  hazard_match #(
    .REG_AW(REG_AW),
    .STAGES(STAGES),
    .TW    (TW),
    .SELW  (SELW)
  ) u_rs (
    .v     (v),
    .dst   (dst),
    .tnew  (tnew),
    .use_en(bus.id_use_rs),
    .src   (bus.id_rs),
    .tuse  (bus.id_tuse_rs),
    .hz    (hz_rs),
    .sel   (bus.fwd_rs_sel),
    .pend  (bus.pend_rs)
  );

  hazard_match #(
    .REG_AW(REG_AW),
    .STAGES(STAGES),
    .TW    (TW),
    .SELW  (SELW)
  ) u_rt (
    .v     (v),
    .dst   (dst),
    .tnew  (tnew),
    .use_en(bus.id_use_rt),
    .src   (bus.id_rt),
    .tuse  (bus.id_tuse_rt),
    .hz    (hz_rt),
    .sel   (bus.fwd_rt_sel),
    .pend  (bus.pend_rt)
  );

  assign bus.stall = bus.id_valid
                   && (hz_rs || hz_rt);

  // Only real writers of a non-zero register get tracked.
  assign load = bus.id_valid && !bus.stall
             && !bus.flush && bus.id_wr_en
             && (bus.id_dst != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v    <= '0;
      dst  <= '0;
      tnew <= '0;
    end else begin
      v[1]    <= load;
      dst[1]  <= load ? bus.id_dst  : '0;
      tnew[1] <= load ? bus.id_tnew : '0;
      for (int k = 2; k <= STAGES; k++) begin
        v[k]    <= v[k-1];
        dst[k]  <= dst[k-1];
        tnew[k] <= (tnew[k-1] == '0)
                 ? '0 : tnew[k-1] - TW'(1);
      end
    end
  end

`ifdef HAZ_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_cnt <= '0;
    else if (bus.stall)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table,
// hand sequences and randomized run against a model.
module tb_hazard_scoreboard;

  localparam int AW = 5;
  localparam int ST = 3;
  localparam int TW = 2;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(
    .REG_AW(AW), .TW(TW), .SELW(SW)
  ) bus ();

`ifdef HAZ_STATS_EN
  logic [31:0] stall_cnt;
`endif

  hazard_scoreboard #(
    .REG_AW(AW), .STAGES(ST),
    .TW(TW), .SELW(SW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus)
`ifdef HAZ_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    logic       vld;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [1:0] trs;
    logic [1:0] trt;
    logic       wr;
    logic [4:0] dst;
    logic [1:0] tnew;
    logic       fl;
    logic       e_st;
    logic [1:0] e_rs;
    logic [1:0] e_rt;
    logic       e_prs;
    logic       e_prt;
  } vec_t;

  // Model: every accepted writer with the edge count at
  // which it entered E; its stage and remaining Tnew follow
  // from its age.
  typedef struct {
    int dst;
    int tnew;
    int born;
  } ent_t;

  ent_t q[$];
  int   cyc;
  int   ecnt;
  int   ncmp;
  int   nerr;
  bit   mst;

  task automatic chk(input string nm,
                     input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  function automatic void look(
    input bit u, input int r, input int tu,
    output bit hz, output int sel, output bit pd);
    int age;
    int rem;
    hz  = 1'b0;
    sel = 0;
    pd  = 1'b0;
    if (!u || r == 0) return;
    for (int i = q.size() - 1; i >= 0; i--) begin
      age = cyc - q[i].born;
      if (age < 0 || age >= ST) continue;
      if (q[i].dst != r) continue;
      rem = (q[i].tnew > age) ? q[i].tnew - age : 0;
      if (rem > tu) hz = 1'b1;
      else if (rem == 0) sel = age + 1;
      else pd = 1'b1;
      return;
    end
  endfunction

  task automatic drive(input vec_t v);
    bus.id_valid   = v.vld;
    bus.id_rs      = v.rs;
    bus.id_rt      = v.rt;
    bus.id_use_rs  = v.urs;
    bus.id_use_rt  = v.urt;
    bus.id_tuse_rs = v.trs;
    bus.id_tuse_rt = v.trt;
    bus.id_wr_en   = v.wr;
    bus.id_dst     = v.dst;
    bus.id_tnew    = v.tnew;
    bus.flush      = v.fl;
  endtask

  task automatic model_reset();
    q.delete();
    cyc  = 0;
    ecnt = 0;
  endtask

  // One decode cycle: drive, check, clock, update model.
  task automatic run(input vec_t v, input bit tbl,
                     input string nm);
    bit hs, ht, ps, pt;
    int ss, sr;
    @(negedge clk);
    drive(v);
    #1;
    look(v.urs, int'(v.rs), int'(v.trs), hs, ss, ps);
    look(v.urt, int'(v.rt), int'(v.trt), ht, sr, pt);
    mst = v.vld && (hs || ht);
    if (tbl) begin
      chk({nm, ".stall"}, int'(bus.stall), int'(v.e_st));
      if (!v.e_st) begin
        chk({nm, ".rs_sel"}, int'(bus.fwd_rs_sel),
            int'(v.e_rs));
        chk({nm, ".rt_sel"}, int'(bus.fwd_rt_sel),
            int'(v.e_rt));
        chk({nm, ".pend_rs"}, int'(bus.pend_rs),
            int'(v.e_prs));
        chk({nm, ".pend_rt"}, int'(bus.pend_rt),
            int'(v.e_prt));
      end
    end else begin
      chk({nm, ".stall"}, int'(bus.stall), int'(mst));
      if (!mst) begin
        chk({nm, ".rs_sel"}, int'(bus.fwd_rs_sel), ss);
        chk({nm, ".rt_sel"}, int'(bus.fwd_rt_sel), sr);
        chk({nm, ".pend_rs"}, int'(bus.pend_rs), int'(ps));
        chk({nm, ".pend_rt"}, int'(bus.pend_rt), int'(pt));
      end
`ifdef HAZ_STATS_EN
      chk({nm, ".stall_cnt"}, int'(stall_cnt), ecnt);
`endif
    end
    @(posedge clk);
    if (v.vld && !mst && !v.fl && v.wr && v.dst != 0)
      q.push_back('{int'(v.dst), int'(v.tnew), cyc + 1});
    if (mst) ecnt++;
    cyc++;
    while (q.size() > 0 && cyc - q[0].born >= ST)
      void'(q.pop_front());
  endtask

  vec_t tbl[25];
  vec_t nop;
  vec_t rv;

  initial begin
    ncmp = 0;
    nerr = 0;
    model_reset();
    nop = '{0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0};

    // lw $8 / addu rs=$8
    tbl[0]  = '{1,0,0,0,0,0,0,1,8,2,0, 0,0,0,0,0};
    tbl[1]  = '{1,8,0,1,0,1,0,1,9,1,0, 1,0,0,0,0};
    tbl[2]  = '{1,8,0,1,0,1,0,1,9,1,0, 0,0,0,1,0};
    tbl[3]  = '{1,0,8,0,1,0,2,0,0,0,0, 0,0,3,0,0};
    tbl[4]  = nop;
    tbl[5]  = nop;
    // addu $9 / beq rs=$9
    tbl[6]  = '{1,0,0,0,0,0,0,1,9,1,0, 0,0,0,0,0};
    tbl[7]  = '{1,9,0,1,0,0,0,0,0,0,0, 1,0,0,0,0};
    tbl[8]  = '{1,9,0,1,0,0,0,0,0,0,0, 0,2,0,0,0};
    tbl[9]  = nop;
    // $0 writer and reader
    tbl[10] = '{1,0,0,0,0,0,0,1,0,2,0, 0,0,0,0,0};
    tbl[11] = '{1,0,0,1,1,0,0,0,0,0,0, 0,0,0,0,0};
    tbl[12] = '{1,0,0,1,1,0,0,0,0,0,0, 0,0,0,0,0};
    // two $5 writers, youngest wins
    tbl[13] = '{1,0,0,0,0,0,0,1,5,0,0, 0,0,0,0,0};
    tbl[14] = '{1,0,0,0,0,0,0,1,5,0,0, 0,0,0,0,0};
    tbl[15] = '{1,5,5,1,1,0,1,0,0,0,0, 0,1,1,0,0};
    tbl[16] = nop;
    tbl[17] = nop;
    // flushed lw $4
    tbl[18] = '{1,0,0,0,0,0,0,1,4,2,1, 0,0,0,0,0};
    tbl[19] = '{1,4,0,1,0,0,0,0,0,0,0, 0,0,0,0,0};
    // flush with stall, 2-cycle stall
    tbl[20] = '{1,0,0,0,0,0,0,1,4,2,0, 0,0,0,0,0};
    tbl[21] = '{1,4,0,1,0,0,0,1,7,1,1, 1,0,0,0,0};
    tbl[22] = '{1,4,0,1,0,0,0,0,0,0,0, 1,0,0,0,0};
    tbl[23] = '{1,4,0,1,0,0,0,0,0,0,0, 0,3,0,0,0};
    tbl[24] = nop;

    // reset state with a reader of $8 presented
    reset_n = 1'b0;
    drive(tbl[2]);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.stall", int'(bus.stall), 0);
    chk("rst.rs_sel", int'(bus.fwd_rs_sel), 0);
    chk("rst.pend_rs", int'(bus.pend_rs), 0);
`ifdef HAZ_STATS_EN
    chk("rst.stall_cnt", int'(stall_cnt), 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 25; i++)
      run(tbl[i], 1'b1, $sformatf("vec%0d", i));

    // reset asserted mid-way through a 2-cycle stall
    run(tbl[0], 1'b1, "rs_lw");
    rv = '{1,8,0,1,0,0,0,0,0,0,0, 1,0,0,0,0};
    run(rv, 1'b1, "rs_st0");
    @(negedge clk);
    #1;
    chk("rs_st1.stall", int'(bus.stall), 1);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rs_async.stall", int'(bus.stall), 0);
`ifdef HAZ_STATS_EN
    chk("rs_async.stall_cnt", int'(stall_cnt), 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rs_post.stall", int'(bus.stall), 0);
    chk("rs_post.rs_sel", int'(bus.fwd_rs_sel), 0);
    run(nop, 1'b1, "rs_idle");

`ifdef HAZ_STATS_EN
    for (int j = 0; j < 2; j++) begin
      run(tbl[6], 1'b1, "cnt_addu");
      run(tbl[7], 1'b1, "cnt_beq0");
      run(tbl[8], 1'b1, "cnt_beq1");
    end
    @(negedge clk);
    #1;
    chk("cnt_two", int'(stall_cnt), 2);
`endif

    // randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      rv.vld  = ($urandom_range(0, 9) != 0);
      rv.rs   = 5'($urandom_range(0, 7));
      rv.rt   = 5'($urandom_range(0, 7));
      rv.urs  = 1'($urandom_range(0, 1));
      rv.urt  = 1'($urandom_range(0, 1));
      rv.trs  = 2'($urandom_range(0, 3));
      rv.trt  = 2'($urandom_range(0, 3));
      rv.wr   = 1'($urandom_range(0, 1));
      rv.dst  = 5'($urandom_range(0, 7));
      rv.tnew = 2'($urandom_range(0, 3));
      rv.fl   = ($urandom_range(0, 15) == 0);
      rv.e_st  = 1'b0;
      rv.e_rs  = 2'd0;
      rv.e_rt  = 2'd0;
      rv.e_prs = 1'b0;
      rv.e_prt = 1'b0;
      run(rv, 1'b0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised Tuse/Tnew hazard scoreboard for the pipelined MIPS core. It sits beside the decode stage and is fed by the per-instruction Tuse/Tnew decoder. It keeps a per-stage record of in-flight destination registers with live Tnew countdowns, and each cycle produces the decode stall and the forward-source selects for rs and rt. It generalises register-address width, tracked pipeline depth and Tnew range, and adds flush, bubble insertion and an optional stall counter.

## Interface

- `REG_AW`, 5: register-address width.
- `STAGES`, 3: tracked stages after decode; 1 = E, 2 = M, 3 = W.
- `TW`, 2: Tuse/Tnew field width.
- `SELW`, $clog2(STAGES+1): forward-select width.
- `clk` input 1: the only clock.
- `reset_n` input 1: asynchronous active-low reset.
- `id_valid` input 1: decode holds a real instruction.
- `id_rs`, `id_rt` input REG_AW: source registers.
- `id_use_rs`, `id_use_rt` input 1: operand is actually read.
- `id_tuse_rs`, `id_tuse_rt` input TW: cycles until the operand is needed.
- `id_wr_en` input 1: instruction writes a register.
- `id_dst` input REG_AW: destination register.
- `id_tnew` input TW: cycles after entering E until the result can be forwarded.
- `flush` input 1: kill the instruction entering E this cycle.
- `stall` output 1: hold PC and the IF/ID register; insert a bubble into E.
- `fwd_rs_sel`, `fwd_rt_sel` output SELW: 0 = register file, k = stage k.
- `pend_rs`, `pend_rt` output 1: the producer is not ready yet but the operand is late enough; a downstream forward is required.
- `stall_cnt` output 32: present only with the macro.

## Operation

- Each stage entry k holds `v[k]`, `dst[k]` and `tnew[k]`. Entries are written only when `id_wr_en` is set and `id_dst` is not 0.
- Every clock, entry k+1 takes entry k, with tnew decremented and saturated at 0. The entry in stage STAGES retires.
- Entry 1 takes the decode instruction only when `id_valid`, `!stall` and `!flush`. In every other case it takes a bubble (`v` = 0).
- Operand match (rs shown; rt is identical):
  - Consider only when `id_use_rs` is set and `id_rs` is not 0.
  - Find the smallest k (youngest) with `v[k]` set and `dst[k] == id_rs`. No match gives select 0 and `pend` 0.
  - `tnew[k] > id_tuse_rs` gives `stall` = 1.
  - `tnew[k] == 0` gives `fwd_rs_sel` = k.
  - Otherwise `pend_rs` = 1 and the select is 0.
- `stall` is the OR of the rs and rt stall terms, gated by `id_valid`.
- When `stall` is 1, `fwd_*_sel` and `pend_*` are don't-care but must be deterministic.
- The register file writes on the clock edge, so stage STAGES with tnew 0 must be selectable as a forward source.
- Simultaneous `flush` and `stall`: entry 1 becomes a bubble and `stall` is still output.

## Timing

- `stall`, `fwd_*_sel` and `pend_*` are combinational from registered entries and decode inputs. Zero-cycle latency.
- Entries update on the rising edge of `clk`.
- A stall lasts exactly `tnew[k] - tuse` cycles with no other activity.
- Reset values: all `v` = 0, `dst` = 0, `tnew` = 0. Therefore `stall` = 0, selects = 0, `pend` = 0, `stall_cnt` = 0.
- Reset asserted mid-stall clears everything immediately. The first cycle after release shows no hazard.

## Configuration

- `HAZ_STATS_EN`
  - Defined: `stall_cnt` port exists. It increments on every clock with `stall` = 1 and wraps at 2^32.
  - Undefined: no port and no counter logic. All other behaviour is identical.

## Structure

- Shared package `hazard_pkg`:
  - TW and stage-index constants.
  - Class Tnew constants: ALU = 1, LOAD = 2, LINK = 0.
  - Class Tuse constants: BRANCH/JR = 0, ALU = 1, STORE_RT = 2.
  - Select encoding: 0 = register file.
- Sub-module `hazard_match`: a youngest-match priority finder plus the stall/forward/pending decision for one operand, instantiated twice (rs, rt).

## Test plan

- lw $8 in E (tnew 2), then addu using rs=$8 (tuse 1):
  - Cycle 0: stall = 1.
  - Cycle 1: stall = 0 and pend_rs = 1.
  - Cycle 2 (once the addu reaches E): sel 0.
- addu $9 in E (tnew 1), then beq using rs=$9 (tuse 0):
  - Cycle 0: stall = 1.
  - Cycle 1: stall = 0 and fwd_rs_sel = 2.
- A writer of $0 with tnew 2 followed by a reader of $0: stall = 0 and sel = 0 throughout.
- $5 in stage 1 (tnew 0) and $5 in stage 2: fwd_rt_sel = 1, because the youngest match wins.
- flush together with a valid lw $4: the next cycle shows no hazard on $4, so stall = 0 for a tuse-0 reader.
- Reset asserted during a 2-cycle stall: stall = 0 asynchronously and stall_cnt = 0. With `HAZ_STATS_EN`, two clean stalls give stall_cnt = 2.
